image_axi_slave: RTL

AXI4 responder for the ImageController register/data window at 0x00_A001_0000, the PS-facing end of the link the host driver uses to configure image size and stream pixel words. Decodes single-beat and INCR bursts on a 128-bit AXI4 slave port, forwards pixel beats to the downstream image buffer with backpressure, and raises a level interrupt when the buffer requests a new frame chunk until the host acknowledges it.

---
 rtl/image_axi_slave.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/image_axi_slave.sv
// AXI4 slave for the ImageController register/data window.
// Write side: image size register, pixel streaming port with downstream
// backpressure, and interrupt acknowledge. Read side: status register.
// Read and write channels run on independent state machines.
module image_axi_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 39,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ID_WIDTH   = 17,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 39'h00_A001_0000
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  // write address
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [15:0]               s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // write response
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // read address
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // read data
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  // image buffer side
  output logic [31:0]               image_width,
  output logic [31:0]               image_height,
  output logic [AXI_DATA_WIDTH-1:0] pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  input  logic                      data_request,
  output logic                      data_done,
  output logic                      irq_signal
);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_SIZE   = 8'h20;
  localparam logic [7:0] OFF_PIX    = 8'h30;
  localparam logic [7:0] OFF_ACK    = 8'h40;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // write channel state
  wstate_t                   r_wstate;
  logic                      r_awready;
  logic [7:0]                r_aw_off;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  logic [1:0]                r_bresp;
  logic                      r_bvalid;

  // read channel state
  rstate_t                   r_rstate;
  logic                      r_arready;
  logic [7:0]                r_ar_off;
  logic [7:0]                r_arlen;
  logic [7:0]                r_rbeat;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_rresp;
  logic                      r_rlast;
  logic                      r_rvalid;

  // register file
  logic [31:0]               r_width;
  logic [31:0]               r_height;
  logic [15:0]               r_beat_cnt;
  logic                      r_irq;
  logic                      r_data_done;

  logic                      w_pix_off;
  logic                      w_wready;
  logic                      w_wbeat;
  logic                      w_pix_beat;
  logic                      w_ack_beat;
  logic                      w_size_beat;
  logic                      w_wr_mapped;
  logic [AXI_DATA_WIDTH-1:0] w_status;
  logic                      w_unused;

  assign w_pix_off   = (r_aw_off == OFF_PIX);
  assign w_wready    = (r_wstate == W_DATA) && (!w_pix_off || pix_ready);
  assign w_wbeat     = w_wready && s_axi_wvalid;
  assign w_pix_beat  = w_wbeat && w_pix_off;
  assign w_ack_beat  = w_wbeat && (r_aw_off == OFF_ACK);
  assign w_size_beat = w_wbeat && (r_aw_off == OFF_SIZE);
  assign w_wr_mapped = (r_aw_off == OFF_SIZE) || (r_aw_off == OFF_PIX) ||
                       (r_aw_off == OFF_ACK);
  assign w_status    = {64'h0, 16'h0, r_beat_cnt, 31'h0, r_irq};

  // Address bits above the 8-bit offset, size/burst/len on AW, and strobes
  // carry no meaning for this window.
  assign w_unused = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:8], s_axi_awsize,
                      s_axi_awburst, s_axi_awlen, s_axi_wstrb,
                      s_axi_araddr[AXI_ADDR_WIDTH-1:8], s_axi_arsize,
                      s_axi_arburst, BASE_ADDR};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rvalid  = r_rvalid;
  assign image_width   = r_width;
  assign image_height  = r_height;
  assign pix_valid     = (r_wstate == W_DATA) && w_pix_off && s_axi_wvalid;
  assign pix_data      = pix_valid ? s_axi_wdata : '0;
  assign data_done     = r_data_done;
  assign irq_signal    = r_irq;

  // Write FSM: address latch, data beats until wlast, then single B response.
  // awready is a register mirroring W_IDLE so it stays low while in reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_aw_off  <= '0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready && s_axi_awvalid) begin
            r_wstate  <= W_DATA;
            r_awready <= 1'b0;
            r_bid     <= s_axi_awid;
            r_aw_off  <= s_axi_awaddr[7:0];
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_wbeat && s_axi_wlast) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_mapped ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Register side effects of accepted write beats and the interrupt level.
  // A request in the same cycle as an ack keeps the interrupt raised.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_width     <= '0;
      r_height    <= '0;
      r_beat_cnt  <= '0;
      r_irq       <= 1'b0;
      r_data_done <= 1'b0;
    end else begin
      r_data_done <= w_ack_beat;
      if (w_size_beat) begin
        r_width  <= s_axi_wdata[31:0];
        r_height <= s_axi_wdata[63:32];
      end
      if (w_ack_beat) begin
        r_beat_cnt <= '0;
      end else if (w_pix_beat) begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if (data_request) begin
        r_irq <= 1'b1;
      end else if (w_ack_beat) begin
        r_irq <= 1'b0;
      end
    end
  end

  // Read FSM: one beat per cycle while rready, register re-sampled per beat,
  // outputs held while the master stalls.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_ar_off  <= '0;
      r_arlen   <= '0;
      r_rbeat   <= '0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready && s_axi_arvalid) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rid     <= s_axi_arid;
            r_ar_off  <= s_axi_araddr[7:0];
            r_arlen   <= s_axi_arlen;
            r_rbeat   <= '0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (s_axi_arlen == 8'd0);
            if (s_axi_araddr[7:0] == OFF_STATUS) begin
              r_rdata <= w_status;
              r_rresp <= RESP_OKAY;
            end else begin
              r_rdata <= '0;
              r_rresp <= RESP_SLVERR;
            end
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (r_rlast) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rdata   <= '0;
              r_arready <= 1'b1;
            end else begin
              r_rbeat <= r_rbeat + 8'd1;
              r_rlast <= ((r_rbeat + 8'd1) == r_arlen);
              r_rdata <= (r_ar_off == OFF_STATUS) ? w_status : '0;
            end
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
